mem_port_ctrl: RTL and testbench

Owns MAR and MDR and runs the memory read/write handshake for the datapath. Loads MAR/MDR from `BusMuxOut` and drives their contents back onto the bus as `BusMuxIn_MAR`/`BusMuxIn_MDR`, so it sits directly upstream of the bus mux. Performs req/ack transactions with word-addressed memory, with timeout detection.

---
 rtl/mem_port_ctrl.sv | 117 +++++++++++
 tb/tb_mem_port_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// MAR/MDR owner and req/ack memory port sequencer for the datapath bus.
// Word-addressed memory with a bounded wait and a sticky timeout flag.
module mem_port_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       BusMuxIn_MAR,
  output logic [31:0]       BusMuxIn_MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mar_q, mar_d;
  logic [31:0]   mdr_q, mdr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic rd_start;
  logic wr_start;

  // Read start wins over a simultaneous write request.
  assign rd_start = MDRin & Read;
  assign wr_start = Write & ~rd_start;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (MARin) mar_d = BusMuxOut;
        if (MDRin && !Read) mdr_d = BusMuxOut;
        if (rd_start) begin
          state_d = S_READ;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (wr_start) begin
          state_d = S_WRITE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_READ, S_WRITE: begin
        // Ack on the final counted edge still completes normally.
        if (mem_ack) begin
          if (state_q == S_READ) mdr_d = mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BusMuxIn_MAR = mar_q;
  assign BusMuxIn_MDR = mdr_q;
  assign mem_addr     = mar_q[ADDR_W-1:0];
  assign mem_wdata    = mdr_q;
  assign mem_rd       = (state_q == S_READ);
  assign mem_wr       = (state_q == S_WRITE);
  assign busy         = mem_rd | mem_wr;
  assign done         = (state_q == S_DONE);
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: load, write, read, timeout,
// ignored controls, read/write collision and async abort.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] BusMuxIn_MAR, BusMuxIn_MDR;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr, busy, done, timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_ctrl #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .BusMuxOut(BusMuxOut),
    .MARin(MARin),
    .MDRin(MDRin),
    .Read(Read),
    .Write(Write),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .BusMuxIn_MAR(BusMuxIn_MAR),
    .BusMuxIn_MDR(BusMuxIn_MDR),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;
    #2;
    total++;
    if ({BusMuxIn_MAR, BusMuxIn_MDR} !== 64'h0) begin
      bad++;
      $display("FAIL reset_regs: got %h %h want 0 0", BusMuxIn_MAR, BusMuxIn_MDR);
    end
    total++;
    if ({mem_rd, mem_wr, busy, done, timeout_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {mem_rd, mem_wr, busy, done, timeout_err});
    end
    nxt(); nxt();
    clr_n = 1'b1;
    nxt();
  endtask

  task automatic test_write();
    BusMuxOut = 32'h0000_0020; MARin = 1;
    nxt();
    MARin = 0; BusMuxOut = 32'hDEAD_BEEF; MDRin = 1;
    nxt();
    MDRin = 0; Write = 1;
    nxt();
    Write = 0;
    total++;
    if ({mem_addr, mem_wdata} !== {9'h020, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL wr_addr_data: got %h %h want 020 deadbeef", mem_addr, mem_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({mem_wr, busy, done} !== 3'b110) begin
        bad++;
        $display("FAIL wr_active[%0d]: got %b want 110", i, {mem_wr, busy, done});
      end
      if (i == 2) mem_ack = 1;
      nxt();
    end
    mem_ack = 0;
    total++;
    if ({mem_wr, busy, done, timeout_err} !== 4'b0010) begin
      bad++;
      $display("FAIL wr_done: got %b want 0010", {mem_wr, busy, done, timeout_err});
    end
    nxt();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL wr_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_read_fast();
    mem_rdata = 32'h1234_5678; mem_ack = 1;
    MDRin = 1; Read = 1;
    nxt();
    MDRin = 0; Read = 0;
    total++;
    if ({mem_rd, busy, done} !== 3'b110) begin
      bad++;
      $display("FAIL rd_start: got %b want 110", {mem_rd, busy, done});
    end
    nxt();
    mem_ack = 0;
    total++;
    if (BusMuxIn_MDR !== 32'h1234_5678 || done !== 1'b1 || mem_rd !== 1'b0) begin
      bad++;
      $display("FAIL rd_fast: got %h done=%b rd=%b want 12345678 1 0",
               BusMuxIn_MDR, done, mem_rd);
    end
    nxt();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    mem_rdata = 32'hAAAA_5555;
    MDRin = 1; Read = 1;
    nxt();
    MDRin = 0; Read = 0;
    while (mem_rd === 1'b1 && n < 40) begin
      n++;
      nxt();
    end
    total++;
    if (n !== 15) begin
      bad++;
      $display("FAIL to_rd_cycles: got %0d want 15", n);
    end
    total++;
    if ({done, timeout_err} !== 2'b11 || BusMuxIn_MDR !== 32'h1234_5678) begin
      bad++;
      $display("FAIL to_done: got %b %h want 11 12345678",
               {done, timeout_err}, BusMuxIn_MDR);
    end
    nxt();
    total++;
    if ({done, timeout_err} !== 2'b01) begin
      bad++;
      $display("FAIL to_sticky: got %b want 01", {done, timeout_err});
    end
    Write = 1;
    nxt();
    Write = 0;
    total++;
    if ({mem_wr, timeout_err} !== 2'b10 || mem_wdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL to_clear: got %b %h want 10 12345678",
               {mem_wr, timeout_err}, mem_wdata);
    end
    mem_ack = 1;
    nxt();
    mem_ack = 0;
    nxt();
  endtask

  task automatic test_busy_ignore();
    MDRin = 1; Read = 1;
    nxt();
    MDRin = 0; Read = 0;
    BusMuxOut = 32'h0000_01FF; MARin = 1; Write = 1;
    nxt();
    MARin = 0; Write = 0;
    total++;
    if (BusMuxIn_MAR !== 32'h20 || mem_wr !== 1'b0 || mem_rd !== 1'b1) begin
      bad++;
      $display("FAIL busy_ign: got mar=%h wr=%b rd=%b want 20 0 1",
               BusMuxIn_MAR, mem_wr, mem_rd);
    end
    mem_rdata = 32'hCAFE_F00D; mem_ack = 1;
    nxt();
    mem_ack = 0;
    total++;
    if (done !== 1'b1 || BusMuxIn_MDR !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL busy_done: got %b %h want 1 cafef00d", done, BusMuxIn_MDR);
    end
    nxt();
    total++;
    if ({busy, mem_wr, done} !== 3'b000 || BusMuxIn_MAR !== 32'h20) begin
      bad++;
      $display("FAIL busy_idle: got %b %h want 000 20",
               {busy, mem_wr, done}, BusMuxIn_MAR);
    end
  endtask

  task automatic test_collide();
    int wr_seen;
    wr_seen = 0;
    MDRin = 1; Read = 1; Write = 1;
    nxt();
    MDRin = 0; Read = 0; Write = 0;
    total++;
    if ({mem_rd, mem_wr} !== 2'b10) begin
      bad++;
      $display("FAIL coll_start: got %b want 10", {mem_rd, mem_wr});
    end
    for (int i = 0; i < 5; i++) begin
      if (mem_wr !== 1'b0) wr_seen++;
      mem_ack = (i == 1);
      nxt();
    end
    mem_ack = 0;
    total++;
    if (wr_seen !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL coll_nowr: got wr=%0d busy=%b want 0 0", wr_seen, busy);
    end
  endtask

  task automatic test_mar_same_edge();
    BusMuxOut = 32'h0000_00AB; MARin = 1; Write = 1;
    nxt();
    MARin = 0; Write = 0;
    total++;
    if (mem_addr !== 9'h0AB || mem_wr !== 1'b1) begin
      bad++;
      $display("FAIL mar_same: got %h %b want 0ab 1", mem_addr, mem_wr);
    end
    mem_ack = 1;
    nxt();
    mem_ack = 0;
    nxt();
  endtask

  task automatic test_reset_abort();
    int dn;
    dn = 0;
    MDRin = 1; Read = 1;
    nxt();
    MDRin = 0; Read = 0;
    nxt(); nxt();
    clr_n = 1'b0;
    #1;
    total++;
    if ({BusMuxIn_MAR, BusMuxIn_MDR} !== 64'h0 || {mem_rd, busy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_now: got %h %h %b want 0 0 00",
               BusMuxIn_MAR, BusMuxIn_MDR, {mem_rd, busy});
    end
    nxt();
    clr_n = 1'b1;
    mem_rdata = 32'h5555_AAAA; mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0) dn++;
      nxt();
    end
    mem_ack = 0;
    total++;
    if (dn !== 0 || BusMuxIn_MDR !== 32'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_late: got done=%0d mdr=%h busy=%b want 0 0 0",
               dn, BusMuxIn_MDR, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_fast();
    test_timeout();
    test_busy_ignore();
    test_collide();
    test_mar_same_edge();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
